uart_sum_reader: RTL and testbench
==================================

# uart_sum_reader

Host-side counterpart of the sensor's UART command/response controller. It issues the start command byte through the UART transmitter, then collects the two-byte sum frame returned over the UART receiver, reassembles it into a 16-bit value and flags lost or truncated frames with an inter-byte timeout. It sits between a local requester, such as a loopback test harness or a system controller, and the UART tx/rx pair.

## Interface
Parameters:
- `START_CODE`, default 8'h00: command byte sent to start acquisition.
- `TIMEOUT_CYCLES`, default 50000: maximum idle cycles allowed while waiting for any response byte.
- `TIMER_W`, default 16: timer width. `TIMEOUT_CYCLES` must not exceed 2^`TIMER_W`-1.

Ports:
- `clk`  in  1  system clock. This is the single clock domain.
- `reset_n`  in  1  reset. Asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a read. Sampled only in IDLE.
- `stream`  in  1  when high, frames are received continuously after one command. When low, one frame is received and then the block returns to IDLE.
- `tx_busy`  in  1  the UART transmitter is sending.
- `rx_ready`  in  1  one-cycle strobe: `rx_data` is valid.
- `rx_data`  in  8  received byte.
- `tx_send`  out  1  one-cycle strobe to the UART transmitter.
- `tx_data`  out  8  byte to transmit. Always equals `START_CODE`.
- `sum_data`  out  16  last complete sum. Holds its value between frames.
- `sum_valid`  out  1  one-cycle pulse when `sum_data` updates.
- `timeout_err`  out  1  one-cycle pulse when a frame is abandoned.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SEND_CMD, WAIT_TX, WAIT_B0, WAIT_B1.
- IDLE: on `start`, go to SEND_CMD.
- SEND_CMD: wait while `tx_busy`=1. When `tx_busy`=0, assert `tx_send` for one cycle and go to WAIT_TX.
- WAIT_TX:
  - Ignore `tx_busy` in the first cycle of the state.
  - From the second cycle on, go to WAIT_B0 when `tx_busy`=0.
  - Bytes received in WAIT_TX are discarded.
- WAIT_B0: on `rx_ready`, latch `rx_data` as the low byte and go to WAIT_B1.
- WAIT_B1: on `rx_ready`, set `sum_data` = {`rx_data`, low byte} and pulse `sum_valid`.
  - If `stream`=1, go to WAIT_B0.
  - Otherwise go to IDLE.
- Timeout:
  - In WAIT_B0 and WAIT_B1, the timer counts cycles spent in the state.
  - When the timer reaches `TIMEOUT_CYCLES`-1 with no `rx_ready`, pulse `timeout_err`, go to IDLE and discard the partial low byte. `sum_data` is unchanged.
- Timer:
  - Clears on every state change.
  - Increments otherwise and saturates at its maximum value.
  - It is also used by WAIT_TX for the first-cycle guard.
- `rx_ready` arriving in the same cycle as the timeout: the byte wins and no timeout occurs.
- `start` while `busy`=1 is ignored.
- `stream` falling mid-frame: the current frame completes, then the block goes to IDLE.

## Timing
- Reset state: IDLE, timer = 0, `sum_data` = 0, and `tx_send`, `sum_valid`, `timeout_err`, `busy` all 0. Reset takes effect immediately and can abort any state.
- All outputs are registered.
  - `tx_send` is high in the cycle after SEND_CMD sees `tx_busy`=0.
  - `sum_valid` and the new `sum_data` appear together in the cycle after the second `rx_ready`.
  - `timeout_err` appears in the cycle after the timer reaches its limit.
- Latency from `start` to `tx_send` is 2 cycles when `tx_busy`=0.
- Byte order on the wire: low byte first, then high byte.

## Structure
- Shared package holds:
  - state encoding (localparams, 3 bits);
  - default `START_CODE` value;
  - `TIMEOUT_CYCLES` default.
- One sub-module, `frame_timer`:
  - inputs: clear and enable;
  - output: a saturating `TIMER_W` count;
  - the FSM compares the count against `TIMEOUT_CYCLES`.
- Everything else stays in `uart_sum_reader`: a registered-state FSM, a combinational next-state block, and a registered output block.

## Test plan
- Reset, then `start` with `tx_busy`=0 → `tx_send` pulses 2 cycles later with `tx_data`=0x00. Then rx bytes 0x34 and 0x12 → `sum_data`=0x1234 and `sum_valid` is one cycle wide.
- `tx_busy` held high for 20 cycles after `start` → no `tx_send` until `tx_busy` falls, then exactly one pulse.
- `stream`=1 with frames 0xCD,0xAB then 0x01,0x00 → two `sum_valid` pulses with 0xABCD then 0x0001. `busy` stays 1.
- `TIMEOUT_CYCLES`=100, only one byte 0x55 sent → `timeout_err` pulses 100 cycles after entering WAIT_B1, state returns to IDLE, `sum_data` keeps its old value.
- `rx_ready` in the exact timeout cycle → the byte is accepted and `timeout_err` stays 0.
- `reset_n` asserted in WAIT_B1 → all outputs 0 immediately. A following `start` performs a clean full transaction.

Source files
------------

// File: rtl/uart_sum_reader_pkg.sv
// Shared definitions for the UART sum reader: state encoding and parameter defaults.
package uart_sum_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_CMD = 3'd1,
        ST_WAIT_TX  = 3'd2,
        ST_WAIT_B0  = 3'd3,
        ST_WAIT_B1  = 3'd4
    } state_t;

    localparam logic [7:0] DEFAULT_START_CODE     = 8'h00;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/uart_sum_reader_frame_timer.sv
// Saturating cycle counter used for the WAIT_TX guard and the inter-byte timeout.
module frame_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    output logic [TIMER_W-1:0] count
);

    logic [TIMER_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != {TIMER_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/uart_sum_reader.sv
// Sends the start command over UART, then reassembles two-byte sum frames
// (low byte first) and reports frames abandoned by the inter-byte timeout.
module uart_sum_reader
    import uart_sum_reader_pkg::*;
#(
    parameter logic [7:0] START_CODE     = DEFAULT_START_CODE,
    parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int         TIMER_W        = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stream,
    input  logic        tx_busy,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    output logic [15:0] sum_data,
    output logic        sum_valid,
    output logic        timeout_err,
    output logic        busy
);

    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t             state_reg;
    state_t             state_next;
    logic               timeout_hit;
    logic [TIMER_W-1:0] timer_count;

    logic               tx_send_reg;
    logic [15:0]        sum_data_reg;
    logic               sum_valid_reg;
    logic               timeout_err_reg;
    logic               busy_reg;
    logic [7:0]         low_byte_reg;

    frame_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_next != state_reg),
        .enable  (1'b1),
        .count   (timer_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: begin
                if (!tx_busy) begin
                    state_next = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                // tx_busy may still be low on the first cycle after the send strobe
                if ((timer_count != '0) && !tx_busy) begin
                    state_next = ST_WAIT_B0;
                end
            end
            ST_WAIT_B0: begin
                if (rx_ready) begin
                    state_next = ST_WAIT_B1;
                end else if (timer_count == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_WAIT_B1: begin
                if (rx_ready) begin
                    state_next = stream ? ST_WAIT_B0 : ST_IDLE;
                end else if (timer_count == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_send_reg     <= 1'b0;
            sum_data_reg    <= '0;
            sum_valid_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
            busy_reg        <= 1'b0;
            low_byte_reg    <= '0;
        end else begin
            tx_send_reg     <= (state_reg == ST_SEND_CMD) && !tx_busy;
            sum_valid_reg   <= 1'b0;
            timeout_err_reg <= timeout_hit;
            busy_reg        <= (state_next != ST_IDLE);
            if ((state_reg == ST_WAIT_B0) && rx_ready) begin
                low_byte_reg <= rx_data;
            end
            if ((state_reg == ST_WAIT_B1) && rx_ready) begin
                sum_data_reg  <= {rx_data, low_byte_reg};
                sum_valid_reg <= 1'b1;
            end
            if (timeout_hit) begin
                low_byte_reg <= '0;
            end
        end
    end

    assign tx_send     = tx_send_reg;
    assign tx_data     = START_CODE;
    assign sum_data    = sum_data_reg;
    assign sum_valid   = sum_valid_reg;
    assign timeout_err = timeout_err_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_uart_sum_reader.sv
// Self-checking bench for uart_sum_reader: table-driven frames plus directed
// busy, stream, timeout and reset sequences, with a scoreboard on sum_valid.
module tb_uart_sum_reader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stream;
    logic        tx_busy;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic [15:0] sum_data;
    logic        sum_valid;
    logic        timeout_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int tx_send_cnt = 0;
    int timeout_cnt = 0;
    logic prev_sum_valid = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] last_sum;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[4];

    uart_sum_reader #(
        .START_CODE     (8'h00),
        .TIMEOUT_CYCLES (100),
        .TIMER_W        (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stream      (stream),
        .tx_busy     (tx_busy),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .sum_data    (sum_data),
        .sum_valid   (sum_valid),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard and pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (sum_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sum_valid", 32'(sum_data), 32'hFFFF_FFFF);
                end else begin
                    check("sum_data", 32'(sum_data), 32'(exp_q.pop_front()));
                end
                if (prev_sum_valid) begin
                    check("sum_valid_width", 32'd2, 32'd1);
                end
            end
            if (tx_send) begin
                tx_send_cnt++;
                check("tx_data", 32'(tx_data), 32'h00);
            end
            if (timeout_err) begin
                timeout_cnt++;
            end
        end
        prev_sum_valid = sum_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    // Pulse start and return the number of cycles until tx_send is seen
    task automatic do_start(output int lat);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!tx_send && n < 200) begin
            tick();
            n++;
        end
        if (!tx_send) begin
            check("tx_send_wait_expired", 32'd0, 32'd1);
        end
        lat = n;
    endtask

    task automatic run_frame(input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] exp);
        int lat;
        do_start(lat);
        check("start_to_tx_send_latency", 32'(lat), 32'd2);
        tick();
        check("tx_send_one_cycle", 32'(tx_send), 32'd0);
        repeat (2) tick();
        send_byte(lo);
        exp_q.push_back(exp);
        send_byte(hi);
        last_sum = exp;
        check("sum_data_hold", 32'(sum_data), 32'(exp));
        check("busy_after_single", 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int n;
        int lat;

        vecs[0] = '{lo: 8'h34, hi: 8'h12, exp: 16'h1234};
        vecs[1] = '{lo: 8'hFF, hi: 8'hFF, exp: 16'hFFFF};
        vecs[2] = '{lo: 8'h00, hi: 8'h80, exp: 16'h8000};
        vecs[3] = '{lo: 8'h01, hi: 8'h00, exp: 16'h0001};

        reset_n  = 1'b0;
        start    = 1'b0;
        stream   = 1'b0;
        tx_busy  = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        last_sum = 16'h0000;

        #22;
        check("reset_sum_data", 32'(sum_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_tx_send", 32'(tx_send), 32'd0);
        check("reset_pulses", 32'({sum_valid, timeout_err}), 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].lo, vecs[i].hi, vecs[i].exp);
            repeat (3) tick();
        end

        // Transmitter busy for 20 cycles after start
        tx_busy = 1'b1;
        base = tx_send_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("no_tx_send_while_busy", 32'(tx_send_cnt - base), 32'd0);
        tx_busy = 1'b0;
        repeat (10) tick();
        check("one_tx_send_after_busy", 32'(tx_send_cnt - base), 32'd1);
        send_byte(8'h11);
        exp_q.push_back(16'h2211);
        send_byte(8'h22);
        last_sum = 16'h2211;
        repeat (3) tick();

        // Streaming frames, then stream drops mid-frame
        stream = 1'b1;
        do_start(lat);
        repeat (3) tick();
        send_byte(8'hCD);
        exp_q.push_back(16'hABCD);
        send_byte(8'hAB);
        send_byte(8'h01);
        exp_q.push_back(16'h0001);
        send_byte(8'h00);
        check("busy_while_streaming", 32'(busy), 32'd1);
        send_byte(8'h02);
        stream = 1'b0;
        exp_q.push_back(16'h0002);
        send_byte(8'h00);
        last_sum = 16'h0002;
        check("busy_after_stream_end", 32'(busy), 32'd0);
        repeat (3) tick();

        // Timeout with only the low byte delivered
        base = timeout_cnt;
        do_start(lat);
        repeat (3) tick();
        rx_ready = 1'b1;
        rx_data  = 8'h55;
        tick();
        rx_ready = 1'b0;
        n = 0;
        while (!timeout_err && n < 300) begin
            tick();
            n++;
        end
        check("timeout_delay", 32'(n), 32'd100);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_sum_kept", 32'(sum_data), 32'(last_sum));
        tick();
        check("timeout_one_cycle", 32'(timeout_err), 32'd0);
        check("timeout_count", 32'(timeout_cnt - base), 32'd1);
        repeat (3) tick();

        // High byte arrives in the exact timeout cycle
        base = timeout_cnt;
        do_start(lat);
        repeat (3) tick();
        rx_ready = 1'b1;
        rx_data  = 8'h66;
        tick();
        rx_ready = 1'b0;
        repeat (99) tick();
        rx_ready = 1'b1;
        rx_data  = 8'h77;
        exp_q.push_back(16'h7766);
        tick();
        rx_ready = 1'b0;
        last_sum = 16'h7766;
        repeat (5) tick();
        check("edge_byte_no_timeout", 32'(timeout_cnt - base), 32'd0);
        check("edge_byte_sum", 32'(sum_data), 32'h7766);

        // Reset asserted while waiting for the high byte
        do_start(lat);
        repeat (3) tick();
        send_byte(8'h99);
        reset_n = 1'b0;
        #1;
        check("midreset_sum_data", 32'(sum_data), 32'd0);
        check("midreset_flags", 32'({tx_send, sum_valid, timeout_err, busy}), 32'd0);
        reset_n = 1'b1;
        tick();
        run_frame(8'h5A, 8'hA5, 16'hA55A);
        repeat (3) tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
